id_ex_stage: RTL

- ID/EX pipeline register with integrated load-use hazard detection for the 5-stage, 16-register core.
- Captures decoded operands and control from the ID stage.
- Drives the ID_EX_* register fields consumed by the forwarding unit and the EX stage.
- Generates the stall that freezes PC and IF/ID, and inserts bubbles on load-use hazards and branch flushes.

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/load_use_detect.sv | 32 +++
 rtl/id_ex_stage.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types and widths for the 5-stage, 16-register core.
package pipe_pkg;

  localparam int DATA_W  = 16;
  localparam int REG_AW  = 4;
  localparam int ALUOP_W = 4;

  // EX-stage control bundle carried through the ID/EX register
  typedef struct packed {
    logic               RegWrite;
    logic               MemRead;
    logic               MemWrite;
    logic               MemToReg;
    logic               ALUSrc;
    logic [ALUOP_W-1:0] ALUOp;
    logic               Halt;
  } ex_ctrl_t;

  // A bubble carries no side effects: no write-back, no memory access, no halt
  localparam ex_ctrl_t EX_CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection between the load sitting in ID/EX
// and the instruction currently in ID.
module load_use_detect
  import pipe_pkg::*;
(
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_mem_write,
  input  logic              br_flush,
  input  logic              mem_stall,
  output logic              load_use,
  output logic              hazard_stall
);

  logic hit_a;
  logic hit_b;

  // Store data (rt of a store) is forwarded MEM-to-MEM, so only its base
  // register can cause a stall; a squashed or frozen pipe never stalls.
  always_comb begin
    hit_a        = id_uses_rs & (ex_rd == id_rs);
    hit_b        = id_uses_rt & (ex_rd == id_rt) & ~id_mem_write;
    load_use     = ex_valid & ex_mem_read & (ex_rd != '0) & (hit_a | hit_b);
    hazard_stall = load_use & ~br_flush & ~mem_stall;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and branch flush.
// Optional build macro: ID_EX_HAZARD_STATS_EN adds saturating bubble counters.
// Upstream handshake: hazard_stall high means PC and IF/ID must hold their
// contents this cycle; the ID inputs are then presented again next cycle.
module id_ex_stage
  import pipe_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_stall,
  input  logic               br_flush,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               id_uses_rs,
  input  logic               id_uses_rt,
  input  logic [DATA_W-1:0]  id_rs_val,
  input  logic [DATA_W-1:0]  id_rt_val,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic               id_RegWrite,
  input  logic               id_MemRead,
  input  logic               id_MemWrite,
  input  logic               id_MemToReg,
  input  logic               id_ALUSrc,
  input  logic [ALUOP_W-1:0] id_ALUOp,
  input  logic               id_Halt,
  output logic [REG_AW-1:0]  ID_EX_RegRs,
  output logic [REG_AW-1:0]  ID_EX_RegRt,
  output logic [REG_AW-1:0]  ID_EX_RegRd,
  output logic [DATA_W-1:0]  ID_EX_RsVal,
  output logic [DATA_W-1:0]  ID_EX_RtVal,
  output logic [DATA_W-1:0]  ID_EX_Imm,
  output logic               ID_EX_RegWrite,
  output logic               ID_EX_MemRead,
  output logic               ID_EX_MemWrite,
  output logic               ID_EX_MemToReg,
  output logic               ID_EX_ALUSrc,
  output logic [ALUOP_W-1:0] ID_EX_ALUOp,
  output logic               ID_EX_Halt,
  output logic               ID_EX_Valid,
  output logic               hazard_stall
`ifdef ID_EX_HAZARD_STATS_EN
  ,
  output logic [15:0]        stat_lu_bubbles,
  output logic [15:0]        stat_flush_bubbles
`endif
);

  ex_ctrl_t id_ctrl;
  ex_ctrl_t ctrl_q;
  logic     load_use;

  // Gather the decoded control inputs into one bundle
  always_comb begin
    id_ctrl          = EX_CTRL_BUBBLE;
    id_ctrl.RegWrite = id_RegWrite;
    id_ctrl.MemRead  = id_MemRead;
    id_ctrl.MemWrite = id_MemWrite;
    id_ctrl.MemToReg = id_MemToReg;
    id_ctrl.ALUSrc   = id_ALUSrc;
    id_ctrl.ALUOp    = id_ALUOp;
    id_ctrl.Halt     = id_Halt;
  end

  load_use_detect u_detect (
    .ex_valid     (ID_EX_Valid),
    .ex_mem_read  (ctrl_q.MemRead),
    .ex_rd        (ID_EX_RegRd),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_mem_write (id_MemWrite),
    .br_flush     (br_flush),
    .mem_stall    (mem_stall),
    .load_use     (load_use),
    .hazard_stall (hazard_stall)
  );

  // Pipeline register: reset > freeze > bubble (flush or load-use) > capture
  always_ff @(posedge clk) begin
    if (rst) begin
      ID_EX_RegRs <= '0;
      ID_EX_RegRt <= '0;
      ID_EX_RegRd <= '0;
      ID_EX_RsVal <= '0;
      ID_EX_RtVal <= '0;
      ID_EX_Imm   <= '0;
      ctrl_q      <= EX_CTRL_BUBBLE;
      ID_EX_Valid <= 1'b0;
    end else if (!mem_stall) begin
      if (br_flush || load_use) begin
        // Zeroed specifiers keep the forwarding unit from matching a bubble
        ID_EX_RegRs <= '0;
        ID_EX_RegRt <= '0;
        ID_EX_RegRd <= '0;
        ID_EX_RsVal <= '0;
        ID_EX_RtVal <= '0;
        ID_EX_Imm   <= '0;
        ctrl_q      <= EX_CTRL_BUBBLE;
        ID_EX_Valid <= 1'b0;
      end else begin
        ID_EX_RegRs <= id_rs;
        ID_EX_RegRt <= id_rt;
        ID_EX_RegRd <= id_rd;
        ID_EX_RsVal <= id_rs_val;
        ID_EX_RtVal <= id_rt_val;
        ID_EX_Imm   <= id_imm;
        ctrl_q      <= id_ctrl;
        ID_EX_Valid <= 1'b1;
      end
    end
  end

  assign ID_EX_RegWrite = ctrl_q.RegWrite;
  assign ID_EX_MemRead  = ctrl_q.MemRead;
  assign ID_EX_MemWrite = ctrl_q.MemWrite;
  assign ID_EX_MemToReg = ctrl_q.MemToReg;
  assign ID_EX_ALUSrc   = ctrl_q.ALUSrc;
  assign ID_EX_ALUOp    = ctrl_q.ALUOp;
  assign ID_EX_Halt     = ctrl_q.Halt;

`ifdef ID_EX_HAZARD_STATS_EN
  // Saturating bubble counters; a frozen pipe inserts no bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lu_bubbles    <= '0;
      stat_flush_bubbles <= '0;
    end else if (!mem_stall) begin
      if (br_flush && stat_flush_bubbles != 16'hFFFF)
        stat_flush_bubbles <= stat_flush_bubbles + 16'd1;
      if (!br_flush && load_use && stat_lu_bubbles != 16'hFFFF)
        stat_lu_bubbles <= stat_lu_bubbles + 16'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
